// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: FSM state, word/address
// widths and byte-address to word-index conversion.
package mem_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 16;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int CNT_W  = 15;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/mem_responder_word_ram.sv
// Word-wide RAM: one synchronous write port, one combinational read port.
// Contents are never reset.
module word_ram
  import mem_pkg::*;
#(
  parameter  int Words = 1024,
  localparam int AW    = (Words > 1) ? $clog2(Words) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [Words];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Instruction/data memory responder with a program-load FSM that holds the core
// in reset until the image is streamed in. Optional LoadSum output: LOAD_CHECKSUM_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int IWords = 1024,
  parameter int DWords = 1024
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              LoadValid,
  input  logic [WORD_W-1:0] LoadData,
  input  logic              LoadLast,
  output logic              LoadReady,
  output logic              CpunReset,
  input  logic [ADDR_W-1:0] InstrAddr,
  output logic [WORD_W-1:0] InstrMem,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic [WORD_W-1:0] WriteData,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [WORD_W-1:0] MemData,
  output logic [CNT_W-1:0]  LoadCount,
  output logic              AddrErr
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] LoadSum
`endif
);

  localparam int IAW = (IWords > 1) ? $clog2(IWords) : 1;
  localparam int DAW = (DWords > 1) ? $clog2(DWords) : 1;
  localparam logic [CNT_W-1:0] IWORDS_L = CNT_W'(IWords);
  localparam logic [CNT_W-1:0] DWORDS_L = CNT_W'(DWords);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  load_count_q, load_count_d;
  logic              addr_err_q, addr_err_d;

  logic [IDX_W-1:0]  ifetch_idx, data_idx;
  logic              ifetch_ok, data_ok;
  logic              running, load_xfer, load_ok;

  logic              imem_we;
  logic [IAW-1:0]    imem_waddr, imem_raddr;
  logic [WORD_W-1:0] imem_rdata;
  logic              dmem_we;
  logic [DAW-1:0]    dmem_addr;
  logic [WORD_W-1:0] dmem_rdata;

  always_comb begin
    ifetch_idx = word_idx(InstrAddr);
    data_idx   = word_idx(MemAddr);
    ifetch_ok  = {1'b0, ifetch_idx} < IWORDS_L;
    data_ok    = {1'b0, data_idx} < DWORDS_L;
    running    = (state_q == RUN);
    load_xfer  = (state_q == LOAD) && LoadValid;
    // LoadCount saturates at IWords, so "< IWords" is the not-full test
    load_ok    = load_xfer && (load_count_q < IWORDS_L);

    imem_we    = load_ok;
    imem_waddr = load_count_q[IAW-1:0];
    imem_raddr = ifetch_idx[IAW-1:0];
    dmem_we    = running && MemWrite && data_ok;
    dmem_addr  = data_idx[DAW-1:0];
  end

  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    addr_err_d   = addr_err_q;

    case (state_q)
      LOAD: begin
        if (load_xfer && LoadLast) begin
          state_d = RUN;
        end
        if (load_ok) begin
          load_count_d = load_count_q + CNT_W'(1);
        end
        if (load_xfer && !load_ok) begin
          addr_err_d = 1'b1;
        end
      end
      RUN: begin
        if (!ifetch_ok) begin
          addr_err_d = 1'b1;
        end
        if ((MemRead || MemWrite) && !data_ok) begin
          addr_err_d = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= LOAD;
      load_count_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      addr_err_q   <= addr_err_d;
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [WORD_W-1:0] load_sum_q, load_sum_d;

  // Dropped overflow words still count; only LOAD-state transfers accumulate
  always_comb begin
    load_sum_d = load_sum_q;
    if (load_xfer) begin
      load_sum_d = load_sum_q + LoadData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      load_sum_q <= '0;
    end else begin
      load_sum_q <= load_sum_d;
    end
  end

  assign LoadSum = load_sum_q;
`endif

  word_ram #(.Words(IWords)) u_imem (
    .clk   (Clock),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (LoadData),
    .raddr (imem_raddr),
    .rdata (imem_rdata)
  );

  word_ram #(.Words(DWords)) u_dmem (
    .clk   (Clock),
    .we    (dmem_we),
    .waddr (dmem_addr),
    .wdata (WriteData),
    .raddr (dmem_addr),
    .rdata (dmem_rdata)
  );

  assign LoadReady = !running;
  assign CpunReset = running;
  assign InstrMem  = (running && ifetch_ok) ? imem_rdata : '0;
  assign MemData   = (running && MemRead && data_ok) ? dmem_rdata : '0;
  assign LoadCount = load_count_q;
  assign AddrErr   = addr_err_q;

endmodule
